sha256_stream_driver: RTL and testbench

- Source-side controller for the streaming SHA-256 hasher (StreamingSHA256).
- Accepts a byte-wide valid/ready message stream and packs it big-endian into 32-bit words.
- Sequences the hasher's start/update/finalize inputs, paced so the hasher's 128-byte input FIFO never overflows.
- Captures the hasher's digest and returns it with a per-message error flag.

---
 rtl/sha256_stream_driver.sv | 168 ++++++++++++++++
 tb/tb_sha256_stream_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream_driver.sv
// sha256_stream_driver: packs a byte stream into 32-bit words for a streaming SHA-256 hasher,
// sequences start/update/finalize, and returns the captured digest with an error flag.
// Optional macro SHA256_DRIVER_COMPARE_EN adds an expected-digest input and a match output.
module sha256_stream_driver #(
    parameter int MAX_MSG_BYTES  = 128,
    parameter int FINALIZE_GAP   = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [7:0]   s_data,
    input  logic         s_last,
    output logic         hash_start,
    output logic         hash_update,
    output logic [31:0]  hash_data,
    output logic [2:0]   hash_bytes_valid,
    output logic         hash_finalize,
    input  logic         hash_valid_in,
    input  logic [255:0] hash_in,
`ifdef SHA256_DRIVER_COMPARE_EN
    input  logic [255:0] expected,
    output logic         match,
`endif
    output logic         digest_valid,
    output logic [255:0] digest,
    output logic         msg_error,
    output logic         busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(FINALIZE_GAP + 2);

    typedef enum logic [2:0] {IDLE, START, PACK, GAP, FINALIZE, WAIT_HASH, DONE} state_t;

    state_t        state;
    logic [31:0]   pack;
    logic [1:0]    wi;
    logic [7:0]    byte_cnt;
    logic [TW-1:0] to_cnt;
    logic [GW-1:0] gap_cnt;
    logic          err_sticky;
`ifdef SHA256_DRIVER_COMPARE_EN
    logic [255:0]  exp_q;
`endif

    wire         take      = s_valid && s_ready;
    wire         keep      = 32'(byte_cnt) < MAX_MSG_BYTES;
    wire  [31:0] word_next = pack | ({s_data, 24'd0} >> {wi, 3'b000});

    // Control FSM: every hasher-facing and host-facing output is a register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            s_ready          <= 1'b0;
            hash_start       <= 1'b0;
            hash_update      <= 1'b0;
            hash_data        <= '0;
            hash_bytes_valid <= '0;
            hash_finalize    <= 1'b0;
            digest_valid     <= 1'b0;
            digest           <= '0;
            msg_error        <= 1'b0;
            busy             <= 1'b0;
            pack             <= '0;
            wi               <= '0;
            byte_cnt         <= '0;
            to_cnt           <= '0;
            gap_cnt          <= '0;
            err_sticky       <= 1'b0;
`ifdef SHA256_DRIVER_COMPARE_EN
            match            <= 1'b0;
            exp_q            <= '0;
`endif
        end else begin
            hash_start    <= 1'b0;
            hash_update   <= 1'b0;
            hash_finalize <= 1'b0;
            digest_valid  <= 1'b0;
            case (state)
                IDLE: if (s_valid) begin
                    state      <= START;
                    hash_start <= 1'b1;
                    busy       <= 1'b1;
                end
                START: begin
                    state    <= PACK;
                    s_ready  <= 1'b1;
                    pack     <= '0;
                    wi       <= '0;
                    byte_cnt <= '0;
                end
                PACK: if (take) begin
                    if (byte_cnt != 8'hff) byte_cnt <= byte_cnt + 8'd1;
                    if (keep) begin
                        if (wi == 2'd3 || s_last) begin
                            hash_update      <= 1'b1;
                            hash_data        <= word_next;
                            hash_bytes_valid <= {1'b0, wi} + 3'd1;
                            pack             <= '0;
                            wi               <= '0;
                        end else begin
                            pack <= word_next;
                            wi   <= wi + 2'd1;
                        end
                    end else begin
                        // overflow bytes are dropped; a partial word left behind still gets flushed
                        err_sticky <= 1'b1;
                        if (s_last && wi != 2'd0) begin
                            hash_update      <= 1'b1;
                            hash_data        <= pack;
                            hash_bytes_valid <= {1'b0, wi};
                            pack             <= '0;
                            wi               <= '0;
                        end
                    end
                    if (s_last) begin
                        state   <= GAP;
                        s_ready <= 1'b0;
                        gap_cnt <= '0;
`ifdef SHA256_DRIVER_COMPARE_EN
                        exp_q   <= expected;
`endif
                    end
                end
                GAP: if (gap_cnt == GW'(FINALIZE_GAP)) begin
                    state         <= FINALIZE;
                    hash_finalize <= 1'b1;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                FINALIZE: begin
                    state  <= WAIT_HASH;
                    to_cnt <= '0;
                end
                WAIT_HASH: if (hash_valid_in) begin
                    state        <= DONE;
                    digest       <= hash_in;
                    digest_valid <= 1'b1;
                    msg_error    <= err_sticky;
`ifdef SHA256_DRIVER_COMPARE_EN
                    match        <= (hash_in == exp_q) && !err_sticky;
`endif
                end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state        <= DONE;
                    digest       <= '0;
                    digest_valid <= 1'b1;
                    msg_error    <= 1'b1;
`ifdef SHA256_DRIVER_COMPARE_EN
                    match        <= 1'b0;
`endif
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
                DONE: begin
                    state      <= IDLE;
                    msg_error  <= 1'b0;
                    err_sticky <= 1'b0;
                    busy       <= 1'b0;
`ifdef SHA256_DRIVER_COMPARE_EN
                    match      <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_stream_driver.sv
// tb_sha256_stream_driver: directed bench for sha256_stream_driver with a minimal hasher responder.
module tb_sha256_stream_driver;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] L56_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] L129_DIG = 256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         s_valid = 0;
    logic         s_ready;
    logic [7:0]   s_data = 0;
    logic         s_last = 0;
    logic         hash_start, hash_update, hash_finalize;
    logic [31:0]  hash_data;
    logic [2:0]   hash_bytes_valid;
    logic         hash_valid_in;
    logic [255:0] hash_in;
    logic         digest_valid, msg_error, busy;
    logic [255:0] digest;
`ifdef SHA256_DRIVER_COMPARE_EN
    logic [255:0] expected = 0;
    logic         match;
`endif

    sha256_stream_driver dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .hash_start(hash_start), .hash_update(hash_update), .hash_data(hash_data),
        .hash_bytes_valid(hash_bytes_valid), .hash_finalize(hash_finalize),
        .hash_valid_in(hash_valid_in), .hash_in(hash_in),
`ifdef SHA256_DRIVER_COMPARE_EN
        .expected(expected), .match(match),
`endif
        .digest_valid(digest_valid), .digest(digest), .msg_error(msg_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // hasher responder: returns resp a few cycles after finalize unless respond is cleared
    logic [255:0] resp = 0;
    bit respond = 1;
    bit stray = 0;
    int cd = 0;
    always @(negedge clk) begin
        if (hash_finalize && respond) cd = 5;
        else if (cd > 0) cd = cd - 1;
        hash_valid_in = (cd == 1) || stray;
        hash_in = (cd == 1) ? resp : {8{32'hdeadbeef}};
    end

    // monitor: records hasher-side traffic and digest events mid-cycle
    logic [31:0] upd_w[$];
    logic [2:0]  upd_b[$];
    int          upd_c[$];
    int fin_cyc = 0, dv_n = 0, dv_cyc = 0, first_acc = 0, onehot_bad = 0;
    bit got = 0;
    logic [255:0] dv_dig = 0;
    logic dv_err = 0, dv_match = 0;
    always @(negedge clk) begin
        if (hash_start) got = 0;
        if (s_valid && s_ready && !got) begin
            first_acc = cyc + 1;
            got = 1;
        end
        if (hash_update) begin
            upd_w.push_back(hash_data);
            upd_b.push_back(hash_bytes_valid);
            upd_c.push_back(cyc);
        end
        if (hash_finalize) fin_cyc = cyc;
        if (digest_valid) begin
            dv_n++;
            dv_dig = digest;
            dv_err = msg_error;
            dv_cyc = cyc;
`ifdef SHA256_DRIVER_COMPARE_EN
            dv_match = match;
`endif
        end
        if (int'(hash_start) + int'(hash_update) + int'(hash_finalize) > 1) onehot_bad++;
    end

    int total = 0, bad = 0;
    logic [7:0] m[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int n, input bit stall);
        int i = 0;
        int t = 0;
        bit tog = 0;
        while (i < n && t < 3000) begin
            @(posedge clk); #1;
            t++;
            if (stall && tog) s_valid = 0;
            else begin
                s_valid = 1;
                s_data = m[i];
                s_last = (i == m.size() - 1);
            end
            tog = !tog;
            if (s_valid && s_ready) i++;
        end
        @(posedge clk); #1;
        s_valid = 0;
        s_last = 0;
        check("send_complete", 256'(i), 256'(n));
    endtask

    task automatic wait_dv(input int n0);
        int t = 0;
        while (dv_n == n0 && t < 1500) begin
            @(posedge clk); #1;
            t++;
        end
        check("digest_valid_seen", 256'(dv_n - n0), 256'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic load_abc();
        m.delete();
        m.push_back(8'h61);
        m.push_back(8'h62);
        m.push_back(8'h63);
    endtask

    initial begin
        string s56;
        int ub, dn, nb4;
        s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 256'(busy), 0);
        check("reset_s_ready", 256'(s_ready), 0);
        check("reset_strobes", 256'({hash_start, hash_update, hash_finalize, digest_valid, msg_error}), 0);
        check("reset_digest", digest, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // stray hash_valid_in while idle must be ignored
        dn = dv_n;
        stray = 1;
        @(posedge clk); #1;
        stray = 0;
        repeat (2) @(posedge clk);
        #1;
        check("stray_no_dv", 256'(dv_n - dn), 0);
        check("stray_digest", digest, 0);

        // "abc"
        resp = ABC_DIG;
        load_abc();
        ub = upd_w.size();
        dn = dv_n;
        send(3, 0);
        wait_dv(dn);
        check("abc_nupd", 256'(upd_w.size() - ub), 1);
        check("abc_word", 256'(upd_w[ub]), 256'h61626300);
        check("abc_bv", 256'(upd_b[ub]), 3);
        check("abc_gap", 256'(fin_cyc - upd_c[ub]), 3);
        check("abc_digest", dv_dig, ABC_DIG);
        check("abc_err", 256'(dv_err), 0);

        // 56-byte two-block message
        resp = L56_DIG;
        m.delete();
        for (int i = 0; i < 56; i++) m.push_back(s56[i]);
        ub = upd_w.size();
        dn = dv_n;
        send(56, 0);
        wait_dv(dn);
        nb4 = 0;
        for (int k = ub; k < upd_w.size(); k++) if (upd_b[k] != 3'd4) nb4++;
        check("m56_nupd", 256'(upd_w.size() - ub), 14);
        check("m56_bv_all4", 256'(nb4), 0);
        check("m56_word0", 256'(upd_w[ub]), 256'h61626364);
        check("m56_word1", 256'(upd_w[ub + 1]), 256'h62636465);
        check("m56_word13", 256'(upd_w[ub + 13]), 256'h6e6f7071);
        check("m56_latency", 256'(upd_c[ub] + 1 - first_acc), 4);
        check("m56_digest", dv_dig, L56_DIG);
        check("m56_err", 256'(dv_err), 0);

        // 129-byte overflow message
        resp = L129_DIG;
        m.delete();
        for (int i = 0; i < 129; i++) m.push_back(8'(i));
        ub = upd_w.size();
        dn = dv_n;
        send(129, 0);
        wait_dv(dn);
        nb4 = 0;
        for (int k = ub; k < upd_w.size(); k++) if (upd_b[k] != 3'd4) nb4++;
        check("m129_nupd", 256'(upd_w.size() - ub), 32);
        check("m129_bv_all4", 256'(nb4), 0);
        check("m129_word31", 256'(upd_w[ub + 31]), 256'h7c7d7e7f);
        check("m129_err", 256'(dv_err), 1);

        // stalled "abc"
        resp = ABC_DIG;
        load_abc();
        ub = upd_w.size();
        dn = dv_n;
        send(3, 1);
        wait_dv(dn);
        check("stall_nupd", 256'(upd_w.size() - ub), 1);
        check("stall_word", 256'(upd_w[ub]), 256'h61626300);
        check("stall_bv", 256'(upd_b[ub]), 3);
        check("stall_digest", dv_dig, ABC_DIG);
        check("stall_err", 256'(dv_err), 0);

        // hasher never answers
        respond = 0;
        load_abc();
        dn = dv_n;
        send(3, 0);
        wait_dv(dn);
        check("timeout_err", 256'(dv_err), 1);
        check("timeout_digest", dv_dig, 0);
        check("timeout_cycles", 256'(dv_cyc - fin_cyc), 1024);
        respond = 1;

        // reset in the middle of a message, then a clean "abc"
        m.delete();
        for (int i = 0; i < 20; i++) m.push_back(8'(8'h30 + i));
        dn = dv_n;
        send(10, 0);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        check("midrst_busy", 256'(busy), 0);
        check("midrst_s_ready", 256'(s_ready), 0);
        check("midrst_digest", digest, 0);
        resp = ABC_DIG;
`ifdef SHA256_DRIVER_COMPARE_EN
        expected = ABC_DIG;
`endif
        load_abc();
        send(3, 0);
        wait_dv(dn);
        repeat (20) @(posedge clk);
        #1;
        check("midrst_one_dv", 256'(dv_n - dn), 1);
        check("midrst_digest_abc", dv_dig, ABC_DIG);
        check("midrst_err", 256'(dv_err), 0);
`ifdef SHA256_DRIVER_COMPARE_EN
        check("midrst_match", 256'(dv_match), 1);
`endif

        check("strobes_onehot", 256'(onehot_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
